// File: rtl/gradient_scheduler.sv
// Sequences one gradient engine over NUM_IMAGES back-to-back images, relocating its addresses by a per-image base.
// Optional watchdog: define GRADIENT_SCHED_WATCHDOG_EN to abort a stalled image after TIMEOUT_CYCLES.
module gradient_scheduler #(
  parameter int WIDTH          = 64,
  parameter int HEIGHT         = 64,
  parameter int BIT_DEPTH      = 8,
  parameter int NUM_IMAGES     = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                                         clk_in,
  input  logic                                         rst_in,
  input  logic                                         start_in,
  output logic                                         busy_out,
  output logic                                         all_done_out,
  output logic [$clog2(NUM_IMAGES):0]                  image_idx_out,
  output logic                                         eng_start_out,
  input  logic                                         eng_done_in,
  input  logic [$clog2(WIDTH*HEIGHT)-1:0]              eng_read_addr_in,
  input  logic                                         eng_read_valid_in,
  output logic [BIT_DEPTH-1:0]                         eng_pixel_out,
  input  logic [$clog2(WIDTH*HEIGHT)-1:0]              eng_x_addr_in,
  input  logic [$clog2(WIDTH*HEIGHT)-1:0]              eng_y_addr_in,
  input  logic                                         eng_x_valid_in,
  input  logic                                         eng_y_valid_in,
  input  logic [BIT_DEPTH-1:0]                         eng_x_pixel_in,
  input  logic [BIT_DEPTH-1:0]                         eng_y_pixel_in,
  output logic [$clog2(WIDTH*HEIGHT*NUM_IMAGES)-1:0]   mem_read_addr_out,
  output logic                                         mem_read_valid_out,
  input  logic [BIT_DEPTH-1:0]                         mem_pixel_in,
  output logic [$clog2(WIDTH*HEIGHT*NUM_IMAGES)-1:0]   x_addr_out,
  output logic [$clog2(WIDTH*HEIGHT*NUM_IMAGES)-1:0]   y_addr_out,
  output logic                                         x_valid_out,
  output logic                                         y_valid_out,
  output logic [BIT_DEPTH-1:0]                         x_pixel_out,
  output logic [BIT_DEPTH-1:0]                         y_pixel_out,
  output logic                                         error_out
);
  localparam int GAW = $clog2(WIDTH*HEIGHT*NUM_IMAGES);
  localparam int IW  = $clog2(NUM_IMAGES) + 1;
  localparam logic [GAW-1:0] IMG_WORDS = GAW'(WIDTH*HEIGHT);
  localparam logic [IW-1:0]  LAST_IDX  = IW'(NUM_IMAGES-1);

  typedef enum logic [2:0] {IDLE, LAUNCH, RUN, NEXT, FINISH} state_e;

  state_e         state_q;
  logic [GAW-1:0] base_q;
  logic [IW-1:0]  idx_q;
  logic           start_q, done_q, busy_q;
  logic           run;

`ifdef GRADIENT_SCHED_WATCHDOG_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  logic [TW-1:0] wd_q;
  logic          err_q;
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= IDLE;
      base_q  <= '0;
      idx_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef GRADIENT_SCHED_WATCHDOG_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: if (start_in) begin
          state_q <= LAUNCH;
          start_q <= 1'b1;
          busy_q  <= 1'b1;
`ifdef GRADIENT_SCHED_WATCHDOG_EN
          err_q   <= 1'b0;
`endif
        end
        LAUNCH: begin
          state_q <= RUN;
`ifdef GRADIENT_SCHED_WATCHDOG_EN
          wd_q    <= '0;
`endif
        end
        RUN: begin
          if (eng_done_in) state_q <= NEXT;
`ifdef GRADIENT_SCHED_WATCHDOG_EN
          // Stalled engine: flag and still finish so downstream sees a completion pulse.
          else if (wd_q == TW'(TIMEOUT_CYCLES-1)) begin
            err_q   <= 1'b1;
            state_q <= FINISH;
            done_q  <= 1'b1;
          end else wd_q <= wd_q + 1'b1;
`endif
        end
        NEXT: if (idx_q < LAST_IDX) begin
          state_q <= LAUNCH;
          start_q <= 1'b1;
          idx_q   <= idx_q + 1'b1;
          base_q  <= base_q + IMG_WORDS;
        end else begin
          state_q <= FINISH;
          done_q  <= 1'b1;
        end
        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          idx_q   <= '0;
          base_q  <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign run           = (state_q == RUN);
  assign busy_out      = busy_q;
  assign all_done_out  = done_q;
  assign eng_start_out = start_q;
  assign image_idx_out = idx_q;

  // Combinational relocation keeps the engine's BRAM read latency intact.
  assign mem_read_addr_out  = base_q + GAW'(eng_read_addr_in);
  assign x_addr_out         = base_q + GAW'(eng_x_addr_in);
  assign y_addr_out         = base_q + GAW'(eng_y_addr_in);
  assign mem_read_valid_out = eng_read_valid_in & run;
  assign x_valid_out        = eng_x_valid_in & run;
  assign y_valid_out        = eng_y_valid_in & run;
  assign eng_pixel_out      = mem_pixel_in;
  assign x_pixel_out        = eng_x_pixel_in;
  assign y_pixel_out        = eng_y_pixel_in;

`ifdef GRADIENT_SCHED_WATCHDOG_EN
  assign error_out = err_q;
`else
  assign error_out = 1'b0;
`endif
endmodule

// File: tb/tb_gradient_scheduler.sv
// Randomized scoreboard bench for gradient_scheduler: an N=2 and an N=1 instance share one stimulus stream.
module tb_gradient_scheduler;
  localparam int W = 4, H = 4, BD = 8, N = 2;
  localparam int LAW = $clog2(W*H), GAW = $clog2(W*H*N), GAW1 = $clog2(W*H);

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, done = 1'b0;
  logic rv = 1'b0, xv = 1'b0, yv = 1'b0;
  logic [LAW-1:0] ra = '0, xa = '0, ya = '0;
  logic [BD-1:0]  xp = '0, yp = '0, mp = '0;

  logic busy_a, adn_a, est_a, mrv_a, xv_a, yv_a, err_a;
  logic [$clog2(N):0] idx_a;
  logic [BD-1:0] pix_a, xp_a, yp_a;
  logic [GAW-1:0] mra_a, xa_a, ya_a;

  logic busy_b, adn_b, est_b, mrv_b, xv_b, yv_b, err_b;
  logic [0:0] idx_b;
  logic [BD-1:0] pix_b, xp_b, yp_b;
  logic [GAW1-1:0] mra_b, xa_b, ya_b;

  always #5 clk = ~clk;

  gradient_scheduler #(.WIDTH(W), .HEIGHT(H), .BIT_DEPTH(BD), .NUM_IMAGES(N)) u_dut (
    .clk_in(clk), .rst_in(rst_n), .start_in(start), .busy_out(busy_a), .all_done_out(adn_a),
    .image_idx_out(idx_a), .eng_start_out(est_a), .eng_done_in(done),
    .eng_read_addr_in(ra), .eng_read_valid_in(rv), .eng_pixel_out(pix_a),
    .eng_x_addr_in(xa), .eng_y_addr_in(ya), .eng_x_valid_in(xv), .eng_y_valid_in(yv),
    .eng_x_pixel_in(xp), .eng_y_pixel_in(yp), .mem_read_addr_out(mra_a), .mem_read_valid_out(mrv_a),
    .mem_pixel_in(mp), .x_addr_out(xa_a), .y_addr_out(ya_a), .x_valid_out(xv_a), .y_valid_out(yv_a),
    .x_pixel_out(xp_a), .y_pixel_out(yp_a), .error_out(err_a));

  gradient_scheduler #(.WIDTH(W), .HEIGHT(H), .BIT_DEPTH(BD), .NUM_IMAGES(1)) u_dut1 (
    .clk_in(clk), .rst_in(rst_n), .start_in(start), .busy_out(busy_b), .all_done_out(adn_b),
    .image_idx_out(idx_b), .eng_start_out(est_b), .eng_done_in(done),
    .eng_read_addr_in(ra), .eng_read_valid_in(rv), .eng_pixel_out(pix_b),
    .eng_x_addr_in(xa), .eng_y_addr_in(ya), .eng_x_valid_in(xv), .eng_y_valid_in(yv),
    .eng_x_pixel_in(xp), .eng_y_pixel_in(yp), .mem_read_addr_out(mra_b), .mem_read_valid_out(mrv_b),
    .mem_pixel_in(mp), .x_addr_out(xa_b), .y_addr_out(ya_b), .x_valid_out(xv_b), .y_valid_out(yv_b),
    .x_pixel_out(xp_b), .y_pixel_out(yp_b), .error_out(err_b));

  // Pass-level view of the scheduler: which phase of the image sequence we are in.
  typedef struct {
    bit busy, launch, active, gap, fin;
    int img;
  } mst_t;

  typedef struct {
    int busy, est, adn, idx, mra, mrv, xa, xv, ya, yv, xp, yp, pix;
    int b_busy, b_est, b_adn, b_idx, b_mra, b_mrv, b_yv;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int vectors = 0, miscompares = 0;

  function automatic mst_t mstep(mst_t s, bit st, bit dn, int n);
    mst_t r = s;
    if (s.launch) begin
      r.launch = 0; r.active = 1;
    end else if (s.active) begin
      if (dn) begin r.active = 0; r.gap = 1; end
    end else if (s.gap) begin
      r.gap = 0;
      if (s.img < n-1) begin r.img = s.img + 1; r.launch = 1; end
      else r.fin = 1;
    end else if (s.fin) begin
      r.fin = 0; r.busy = 0; r.img = 0;
    end else if (st) begin
      r.busy = 1; r.launch = 1;
    end
    return r;
  endfunction

  task automatic chk(string nm, int act, int ex);
    vectors++;
    if (act !== ex) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, ex, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("busy", int'(busy_a), me.busy);
      chk("eng_start", int'(est_a), me.est);
      chk("all_done", int'(adn_a), me.adn);
      chk("image_idx", int'(idx_a), me.idx);
      chk("mem_read_addr", int'(mra_a), me.mra);
      chk("mem_read_valid", int'(mrv_a), me.mrv);
      chk("x_addr", int'(xa_a), me.xa);
      chk("x_valid", int'(xv_a), me.xv);
      chk("y_addr", int'(ya_a), me.ya);
      chk("y_valid", int'(yv_a), me.yv);
      chk("x_pixel", int'(xp_a), me.xp);
      chk("y_pixel", int'(yp_a), me.yp);
      chk("eng_pixel", int'(pix_a), me.pix);
      chk("error", int'(err_a), 0);
      chk("n1_busy", int'(busy_b), me.b_busy);
      chk("n1_eng_start", int'(est_b), me.b_est);
      chk("n1_all_done", int'(adn_b), me.b_adn);
      chk("n1_image_idx", int'(idx_b), me.b_idx);
      chk("n1_mem_read_addr", int'(mra_b), me.b_mra);
      chk("n1_mem_read_valid", int'(mrv_b), me.b_mrv);
      chk("n1_y_valid", int'(yv_b), me.b_yv);
    end
  end

  initial begin
    mst_t ma, mb;
    exp_t e;
    int dly, rcnt, t, base;
    bit did_rst;
    ma = '{default: 0};
    mb = '{default: 0};
    dly = 0; rcnt = 0; did_rst = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      t = cyc - 2;
      if (t >= 110 && !did_rst && ma.img == 1 && ma.active && ($urandom % 4 == 0)) begin
        rcnt = 2; did_rst = 1;
      end
      rst_n = !(cyc < 2 || rcnt > 0);
      if (rcnt > 0) rcnt--;
      if (!rst_n) begin ma = '{default: 0}; mb = '{default: 0}; end

      if (ma.launch) dly = $urandom_range(0, 25);
      if (t < 110) begin
        start = (t == 0) || (t == 20);
        done  = (t == 50) || (t == 99) || (t == 105);
      end else begin
        start = ma.busy ? ($urandom % 8 == 0) : ($urandom % 3 == 0);
        if (ma.active) begin
          done = (dly == 0);
          if (dly > 0) dly--;
        end else done = ($urandom % 16 == 0);
      end
      rv = $urandom % 2; xv = $urandom % 2; yv = $urandom % 2;
      ra = LAW'($urandom); xa = LAW'($urandom); ya = LAW'($urandom);
      xp = BD'($urandom); yp = BD'($urandom); mp = BD'($urandom);

      base = ma.img * W * H;
      e.busy = ma.busy; e.est = ma.launch; e.adn = ma.fin; e.idx = ma.img;
      e.mra = base + int'(ra); e.mrv = rv && ma.active;
      e.xa = base + int'(xa); e.xv = xv && ma.active;
      e.ya = base + int'(ya); e.yv = yv && ma.active;
      e.xp = int'(xp); e.yp = int'(yp); e.pix = int'(mp);
      e.b_busy = mb.busy; e.b_est = mb.launch; e.b_adn = mb.fin; e.b_idx = mb.img;
      e.b_mra = mb.img * W * H + int'(ra); e.b_mrv = rv && mb.active; e.b_yv = yv && mb.active;
      q.push_back(e);

      if (rst_n) begin
        ma = mstep(ma, start, done, N);
        mb = mstep(mb, start, done, 1);
      end
    end
    @(posedge clk); #1;
    start = 0; done = 0;
    @(negedge clk); #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
